// File: rtl/led_blink_array.sv
// Multi-channel LED driver: OFF/ON/BLINK per channel, plus PWM when LED_BLINK_PWM_EN is defined.
// Configuration takes one request per two cycles: the accept cycle, then one apply cycle with cfg_ready low.
module led_blink_array #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 26,
  parameter int DUTY_W = 8,
  parameter logic [CNT_W-1:0] DEF_PERIOD = {1'b0, {(CNT_W-1){1'b1}}},
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [DUTY_W-1:0] cfg_duty,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;

  logic                         apply_q;
  logic [CH_W-1:0]              ch_q;
  logic [1:0]                   pmode_q;
  logic [CNT_W-1:0]             pperiod_q;
  logic [NUM_CH-1:0][1:0]       mode_q, mode_d;
  logic [NUM_CH-1:0][CNT_W-1:0] period_q, period_d;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]            blink_q, blink_d;
  logic [NUM_CH-1:0]            led_q, led_d;
  logic [NUM_CH-1:0]            wrap;
  logic [NUM_CH-1:0]            pwm_on;
  logic                         transfer;

`ifdef LED_BLINK_PWM_EN
  logic [DUTY_W-1:0]              pduty_q;
  logic [NUM_CH-1:0][DUTY_W-1:0]  duty_q, duty_d;
  logic [DUTY_W-1:0]              pwm_q, pwm_d;
`else
  logic unused_duty;
  assign unused_duty = ^cfg_duty;
`endif

  assign cfg_ready = ~rst & ~apply_q;
  assign transfer  = cfg_valid & cfg_ready;
  assign tick      = wrap & {NUM_CH{~rst}};
  assign led       = led_q;

  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    blink_d  = blink_q;
    wrap     = '0;
    pwm_on   = '0;
    led_d    = '0;
`ifdef LED_BLINK_PWM_EN
    duty_d = duty_q;
    pwm_d  = pwm_q + 1'b1;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      wrap[i]    = (cnt_q[i] == period_q[i]);
      cnt_d[i]   = wrap[i] ? '0 : cnt_q[i] + 1'b1;
      blink_d[i] = blink_q[i] ^ wrap[i];
      // Out-of-range channel numbers simply match no channel.
      if (apply_q && (ch_q == CH_W'(i))) begin
        mode_d[i]   = pmode_q;
        period_d[i] = pperiod_q;
        cnt_d[i]    = '0;
        blink_d[i]  = 1'b0;
`ifdef LED_BLINK_PWM_EN
        duty_d[i]   = pduty_q;
`endif
      end
`ifdef LED_BLINK_PWM_EN
      pwm_on[i] = (pwm_d < duty_d[i]);
`endif
      // LED register tracks the next channel state so it always matches the state registers.
      case (mode_d[i])
        MODE_OFF:   led_d[i] = 1'b0;
        MODE_ON:    led_d[i] = 1'b1;
        MODE_BLINK: led_d[i] = blink_d[i];
        default:    led_d[i] = pwm_on[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      apply_q   <= 1'b0;
      ch_q      <= '0;
      pmode_q   <= MODE_OFF;
      pperiod_q <= '0;
      mode_q    <= {NUM_CH{MODE_BLINK}};
      period_q  <= {NUM_CH{DEF_PERIOD}};
      cnt_q     <= '0;
      blink_q   <= '0;
      led_q     <= '0;
`ifdef LED_BLINK_PWM_EN
      pduty_q   <= '0;
      duty_q    <= '0;
      pwm_q     <= '0;
`endif
    end else begin
      apply_q  <= transfer;
      mode_q   <= mode_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      blink_q  <= blink_d;
      led_q    <= led_d;
`ifdef LED_BLINK_PWM_EN
      duty_q   <= duty_d;
      pwm_q    <= pwm_d;
`endif
      if (transfer) begin
        ch_q      <= cfg_ch;
        pmode_q   <= cfg_mode;
        pperiod_q <= cfg_period;
`ifdef LED_BLINK_PWM_EN
        pduty_q   <= cfg_duty;
`endif
      end
    end
  end

endmodule

// File: tb/tb_led_blink_array.sv
// Randomized bench for led_blink_array against a cycle-level behavioural model of the channel rules.
// NUM_CH=5 so that channel numbers 5..7 exercise the out-of-range path.
module tb_led_blink_array;
  localparam int NUM_CH = 5;
  localparam int CNT_W  = 4;
  localparam int DUTY_W = 4;
  localparam int CH_W   = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [1:0]        cfg_mode = '0;
  logic [CNT_W-1:0]  cfg_period = '0;
  logic [DUTY_W-1:0] cfg_duty = '0;
  logic [NUM_CH-1:0] led, tick;

  led_blink_array #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DUTY_W(DUTY_W), .DEF_PERIOD(4'd3)
  ) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
    .cfg_duty(cfg_duty), .led(led), .tick(tick)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Reference state: per-channel phase within its period, blink level, settings.
  int m_mode [NUM_CH];
  int m_per  [NUM_CH];
  int m_duty [NUM_CH];
  int m_ph   [NUM_CH];
  bit m_blink[NUM_CH];
  int m_pwm;
  bit m_pend;
  int p_ch, p_mode, p_per, p_duty;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_led();
    logic [31:0] v = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (m_mode[i])
        1: v[i] = 1'b1;
        2: v[i] = m_blink[i];
`ifdef LED_BLINK_PWM_EN
        3: v[i] = (m_pwm < m_duty[i]);
`endif
        default: v[i] = 1'b0;
      endcase
    end
    return v;
  endfunction

  function automatic logic [31:0] m_tick();
    logic [31:0] v = '0;
    for (int i = 0; i < NUM_CH; i++) v[i] = (m_ph[i] == m_per[i]);
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_mode[i] = 2; m_per[i] = 3; m_duty[i] = 0; m_ph[i] = 0; m_blink[i] = 0;
    end
    m_pwm = 0;
    m_pend = 0;
  endtask

  // One clock: compare outputs mid-cycle, then advance the model by the same edge.
  task automatic step();
    bit rdy;
    @(negedge clk);
    rdy = !rst && !m_pend;
    chk("cfg_ready", 32'(cfg_ready), 32'(rdy));
    chk("led", 32'(led), m_led());
    chk("tick", 32'(tick), rst ? 32'd0 : m_tick());
    if (rst) m_reset();
    else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (m_ph[i] == m_per[i]) m_blink[i] = !m_blink[i];
        m_ph[i] = (m_ph[i] + 1) % (m_per[i] + 1);
      end
      m_pwm = (m_pwm + 1) % (1 << DUTY_W);
      if (m_pend) begin
        if (p_ch < NUM_CH) begin
          m_mode[p_ch] = p_mode; m_per[p_ch] = p_per; m_duty[p_ch] = p_duty;
          m_ph[p_ch] = 0; m_blink[p_ch] = 0;
        end
        m_pend = 0;
      end else if (cfg_valid && rdy) begin
        m_pend = 1;
        p_ch = int'(cfg_ch); p_mode = int'(cfg_mode);
        p_per = int'(cfg_period); p_duty = int'(cfg_duty);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Presents a request with cfg_valid high until accepted; leaves cfg_valid high.
  task automatic cfg(input int ch, input int mode, input int per, input int duty, output int waits);
    bit got = 0;
    cfg_ch = CH_W'(ch); cfg_mode = 2'(mode);
    cfg_period = CNT_W'(per); cfg_duty = DUTY_W'(duty);
    cfg_valid = 1'b1;
    waits = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      got = cfg_ready;
      step();
      if (!got) waits++;
    end
    if (!got) chk("cfg_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    cfg_valid = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  int w;

  initial begin
    m_reset();
    @(posedge clk);
    #1;
    idle(3);
    rst = 1'b0;
    idle(20);

    // ch2 BLINK with period 0 toggles every cycle; others keep phase.
    cfg(2, 2, 0, 0, w);
    idle(10);

    // back-to-back ON then OFF on ch1 with cfg_valid held
    cfg(1, 1, 3, 0, w);
    cfg(1, 0, 3, 0, w);
    chk("b2b_gap", 32'(w), 32'd1);
    idle(6);

    // ch0 PWM duty 5 (constant 0 without the PWM build)
    cfg(0, 3, 3, 5, w);
    idle(40);

    // out-of-range channel changes nothing
    cfg(7, 1, 0, 9, w);
    idle(8);

    // reset during the apply cycle of a ch3 update
    cfg(3, 1, 1, 0, w);
    rst = 1'b1;
    chk("apply_ready_low", 32'(cfg_ready), 32'd0);
    idle(3);
    rst = 1'b0;
    idle(10);

    // random traffic
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: idle($urandom_range(1, 6));
        3: begin
          rst = ($urandom_range(0, 5) == 0);
          idle(1);
          rst = 1'b0;
        end
        default: begin
          cfg($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 7),
              $urandom_range(0, 15), w);
          if ($urandom_range(0, 1) == 0) cfg_valid = 1'b0;
        end
      endcase
    end
    idle(5);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
